// File: rtl/rand_scheduler.sv
// rtl/rand_scheduler.sv - shared LFSR random source with round-robin grant and modulo reduction
//
// Purpose:
//   One free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) serves N_REQ
//   requesters. An idle scheduler grants one pending requester round-robin, captures
//   the low 9 LFSR bits as the raw draw, reduces it modulo that requester's range with
//   a 9-step bit-serial restoring divider, and returns the result with a one-cycle ack.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   seed_load  load LFSR with {5'b10101, seed} instead of shifting this cycle
//   seed       11-bit seed value
//   req        per-requester level request, held until ack
//   range_i    packed 11-bit ranges, requester k at [11k+10:11k]
//   ack        one-hot, one-cycle pulse to the served requester
//   rnd_out    reduced draw, valid while ack is nonzero
//   range_err  pulses with ack when the served range was 0
//   busy       high whenever the scheduler is not idle
module rand_scheduler #(
  parameter int          N_REQ       = 4,
  parameter logic [15:0] RESET_STATE = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [10:0]          seed,
  input  logic [N_REQ-1:0]     req,
  input  logic [11*N_REQ-1:0]  range_i,
  output logic [N_REQ-1:0]     ack,
  output logic [8:0]           rnd_out,
  output logic                 range_err,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [15:0]      lfsr_q,   lfsr_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    winner_q, winner_d;
  // Raw draw, shifted left once per division step so bit 8 is always the next dividend bit.
  logic [8:0]       raw_q,    raw_d;
  logic [10:0]      rng_q,    rng_d;
  logic [11:0]      rem_q,    rem_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic [N_REQ-1:0] ack_q,    ack_d;
  logic [8:0]       rnd_q,    rnd_d;
  logic             err_q,    err_d;

  // Round-robin search: first set request starting at rr_ptr and wrapping.
  logic          grant_found;
  logic [PW-1:0] grant_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  // One restoring-division step. The shifted remainder is carried one bit wider than
  // rem so the compare/subtract never loses the top bit; the result always fits in rem.
  logic [12:0] rem_sh;

  always_comb begin
    rem_sh = {rem_q, raw_q[8]};
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    raw_d    = raw_q;
    rng_d    = rng_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    rnd_d    = 9'd0;
    err_d    = 1'b0;

    // The LFSR runs in every state; a seed load replaces the shift for one cycle.
    if (seed_load) begin
      lfsr_d = {5'b10101, seed};
    end else begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          winner_d = grant_idx;
          raw_d    = lfsr_q[8:0];
          rng_d    = range_i[11*int'(grant_idx) +: 11];
          rr_ptr_d = PW'((int'(grant_idx) + 1) % N_REQ);
          rem_d    = 12'd0;
          cnt_d    = 4'd0;
          state_d  = DIV;
        end
      end

      DIV: begin
        rem_d = 12'((rem_sh >= {2'b00, rng_q}) ? (rem_sh - {2'b00, rng_q}) : rem_sh);
        raw_d = {raw_q[7:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // DONE spans two cycles: the first registers the ack pulse, the second
        // (ack_q already set) clears it and returns to IDLE.
        if (ack_q == '0) begin
          ack_d[winner_q] = 1'b1;
          if (rng_q == 11'd0) begin
            err_d = 1'b1;
          end else begin
            rnd_d = rem_q[8:0];
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= RESET_STATE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      raw_q    <= 9'd0;
      rng_q    <= 11'd0;
      rem_q    <= 12'd0;
      cnt_q    <= 4'd0;
      ack_q    <= '0;
      rnd_q    <= 9'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      raw_q    <= raw_d;
      rng_q    <= rng_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      rnd_q    <= rnd_d;
      err_q    <= err_d;
    end
  end

  assign ack       = ack_q;
  assign rnd_out   = rnd_q;
  assign range_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rand_scheduler.sv
// tb/tb_rand_scheduler.sv - directed self-checking bench for rand_scheduler
module tb_rand_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             seed_load = 1'b0;
  logic [10:0]      seed = 11'd0;
  logic [N-1:0]     req = '0;
  logic [11*N-1:0]  range_i = '0;
  logic [N-1:0]     ack;
  logic [8:0]       rnd_out;
  logic             range_err;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rand_scheduler #(.N_REQ(N), .RESET_STATE(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .range_i   (range_i),
    .ack       (ack),
    .rnd_out   (rnd_out),
    .range_err (range_err),
    .busy      (busy)
  );

  // Reference LFSR straight from the polynomial definition.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= {5'b10101, seed};
    else                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation for requester k: request at a negedge, expect ack on the negedge
  // after the 10th edge following capture (the 11th negedge), then ack/busy low.
  task automatic do_draw(input int k, input logic [10:0] r, input bit drop_early,
                         input bit seed_hit, input logic [10:0] sd);
    logic [8:0] raw;
    logic [8:0] exp_rnd;
    int n;
    int busy_cnt;
    bit got;
    @(negedge clk);
    range_i[11*k +: 11] = r;
    req[k] = 1'b1;
    if (seed_hit) begin
      seed_load = 1'b1;
      seed = sd;
    end
    raw = m_lfsr[8:0];
    exp_rnd = (r == 11'd0) ? 9'd0 : 9'(11'(raw) % r);
    n = 0; busy_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      seed_load = 1'b0;
      if (busy) busy_cnt++;
      if (n == 1) begin
        range_i[11*k +: 11] = ~r;
        if (drop_early) req[k] = 1'b0;
      end
      if (ack != '0) got = 1'b1;
    end
    chk("ack_latency", n, 11);
    chk("busy_cycles", busy_cnt, 11);
    chk("ack_onehot", ack, 1 << k);
    chk("rnd_out", rnd_out, exp_rnd);
    chk("range_err", range_err, (r == 11'd0));
    if (r != 11'd0) chk("rnd_lt_range", (11'(rnd_out) < r), 1);
    req[k] = 1'b0;
    @(negedge clk);
    chk("ack_clear", ack, 0);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    logic [8:0] raw_cur;
    logic [15:0] start;
    bit zero_seen;
    bit early_ret;
    int n;
    bit got;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_rnd", rnd_out, 0);
    chk("rst_err", range_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
    rst_n = 1'b1;

    // Range 1 always yields 0
    do_draw(0, 11'd1, 1'b0, 1'b0, 11'd0);

    // Seed load of zero gives 16'hA800, then a range-512 draw returns raw unchanged
    @(negedge clk);
    seed_load = 1'b1;
    seed = 11'h000;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seed_lfsr", dut.lfsr_q, 16'hA800);
    do_draw(1, 11'd512, 1'b0, 1'b0, 11'd0);

    // 1000 model-checked draws with mixed ranges, early req drops and seed collisions
    for (int i = 0; i < 1000; i++) begin
      int k;
      logic [10:0] r;
      k = $urandom_range(0, N - 1);
      case ($urandom_range(0, 7))
        0:       r = 11'd0;
        1:       r = 11'd1;
        2:       r = 11'($urandom_range(512, 2047));
        default: r = 11'($urandom_range(2, 511));
      endcase
      do_draw(k, r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 11'($urandom));
    end

    // Round robin with all requests held, ranges 7, from reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    range_i = {N{11'd7}};
    req = '1;
    rst_n = 1'b1;
    raw_cur = m_lfsr[8:0];
    for (int c = 1; c < 72; c++) begin
      @(negedge clk);
      if (c % 12 == 0) raw_cur = m_lfsr[8:0];
      chk("rr_ack", ack, (c % 12 == 11) ? (1 << ((c / 12) % N)) : 0);
      if (c % 12 == 11) begin
        chk("rr_rnd", rnd_out, 9'(raw_cur % 9'd7));
        chk("rr_lt7", (rnd_out < 9'd7), 1);
      end
    end
    req = '0;
    @(negedge clk);
    chk("rr_idle", busy, 0);

    // Range 0 then range 100 on requester 2
    do_draw(2, 11'd0, 1'b0, 1'b0, 11'd0);
    do_draw(2, 11'd100, 1'b0, 1'b0, 11'd0);

    // Reset during DIV (cnt=4) aborts; first capture afterwards uses 16'hACE1
    @(negedge clk);
    range_i[10:0] = 11'd2047;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_rnd", rnd_out, 0);
    chk("abort_err", range_err, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lfsr", dut.lfsr_q, 16'hACE1);
    repeat (2) @(negedge clk);
    chk("abort_hold_ack", ack, 0);
    rst_n = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack != '0) got = 1'b1;
    end
    chk("post_rst_latency", n, 11);
    chk("post_rst_ack", ack, 4'b0001);
    chk("post_rst_rnd", rnd_out, 9'h0E1);
    req = '0;
    @(negedge clk);

    // Free run: period 65535, never zero
    start = m_lfsr;
    chk("free_start", dut.lfsr_q, start);
    zero_seen = 1'b0;
    early_ret = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk);
      if (dut.lfsr_q == 16'd0) zero_seen = 1'b1;
      if (i < 65535 && dut.lfsr_q == start) early_ret = 1'b1;
    end
    chk("free_zero", zero_seen, 0);
    chk("free_early", early_ret, 0);
    chk("free_period", dut.lfsr_q, start);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
